// File: rtl/mem_access_unit_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_unit_pkg : shared types for the memory access unit
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

package mem_access_unit_pkg;

  localparam int MAU_DEF_WIDTH = 16;
  localparam int MAU_DEF_LANES = MAU_DEF_WIDTH / 8;

  typedef enum logic [1:0] {
    MAU_IDLE  = 2'd0,
    MAU_READ  = 2'd1,
    MAU_WRITE = 2'd2,
    MAU_DONE  = 2'd3
  } lc3b_mau_state;

  typedef logic [MAU_DEF_LANES-1:0] lc3b_mem_wmask;

endpackage : mem_access_unit_pkg

`default_nettype wire

// File: rtl/mem_access_unit_byte_lane.sv
// ---------------------------------------------------------------------------
// mem_access_unit_byte_lane : byte replicate / lane enable / lane extract
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit_byte_lane
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  localparam int LANES = WIDTH / 8,
  localparam int LB = $clog2(LANES)
) (
  input  logic [LB-1:0]    wlane_i,
  input  logic [7:0]       wbyte_i,
  input  logic [LB-1:0]    rlane_i,
  input  logic [WIDTH-1:0] rdata_i,
  output logic [WIDTH-1:0] wdata_rep_o,
  output logic [LANES-1:0] be_onehot_o,
  output logic [WIDTH-1:0] rbyte_o
);

  logic [7:0] w_lane_bytes [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign wdata_rep_o[g*8 +: 8] = wbyte_i;
    assign be_onehot_o[g]        = (wlane_i == LB'(g));
    assign w_lane_bytes[g]       = rdata_i[g*8 +: 8];
  end

  assign rbyte_o = {{(WIDTH-8){1'b0}}, w_lane_bytes[rlane_i]};

endmodule : mem_access_unit_byte_lane

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit : MAR/MDR owner performing one word/byte access per request
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64,
  localparam int LANES  = WIDTH / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WIDTH-1:0]  req_wdata,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [LANES-1:0]  mem_byte_enable,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_resp
);

  localparam int LB    = $clog2(LANES);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(LANES - 1);

  lc3b_mau_state     state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [WIDTH-1:0]  wdata_q, wdata_d;
  logic              byte_q, byte_d;
  logic [LB-1:0]     lane_q, lane_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0]  w_wdata_rep;
  logic [LANES-1:0]  w_be_onehot;
  logic [WIDTH-1:0]  w_rbyte;

  mem_access_unit_byte_lane #(
    .WIDTH (WIDTH)
  ) u_byte_lane (
    .wlane_i     (req_addr[LB-1:0]),
    .wbyte_i     (req_wdata[7:0]),
    .rlane_i     (lane_q),
    .rdata_i     (mem_rdata),
    .wdata_rep_o (w_wdata_rep),
    .be_onehot_o (w_be_onehot),
    .rbyte_o     (w_rbyte)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    cnt_d       = cnt_q;

    case (state_q)
      MAU_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid) begin
          req_ready_d = 1'b0;
          // MAR is always word aligned; the lane is kept for byte reads
          addr_d      = req_addr & ADDR_MASK;
          byte_d      = req_byte;
          lane_d      = req_addr[LB-1:0];
          cnt_d       = '0;
          if (req_we) begin
            state_d = MAU_WRITE;
            wr_d    = 1'b1;
            wdata_d = req_byte ? w_wdata_rep : req_wdata;
            be_d    = req_byte ? w_be_onehot : '1;
          end else begin
            state_d = MAU_READ;
            rd_d    = 1'b1;
            be_d    = '1;
          end
        end
      end

      MAU_READ, MAU_WRITE: begin
        if (mem_resp) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          state_d     = MAU_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          if (state_q == MAU_READ) begin
            rsp_data_d = byte_q ? w_rbyte : mem_rdata;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          state_d     = MAU_DONE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      MAU_DONE: begin
        state_d     = MAU_IDLE;
        req_ready_d = 1'b1;
        cnt_d       = '0;
      end

      default: begin
        state_d     = MAU_IDLE;
        req_ready_d = 1'b1;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MAU_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      byte_q      <= 1'b0;
      lane_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_err         = rsp_err_q;
  assign mem_address     = addr_q;
  assign mem_read        = rd_q;
  assign mem_write       = wr_q;
  assign mem_byte_enable = be_q;
  assign mem_wdata       = wdata_q;

endmodule : mem_access_unit

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit : scoreboard bench for mem_access_unit (TIMEOUT=4)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic [15:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = 16'hDEAD;
  logic        mem_resp = 1'b0;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t        exp_q[$];
  logic [15:0] last_data;
  int          n_checks = 0;
  int          n_errors = 0;

  mem_access_unit #(
    .WIDTH   (16),
    .ADDR_W  (16),
    .TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_we          (req_we),
    .req_byte        (req_byte),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_err         (rsp_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every response is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check("rsp_data", 32'(rsp_data), 32'(e.data));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
    end
    if (mem_read && mem_write) check("strobe_overlap", 32'd1, 32'd0);
  end

  // One request; resp_after==0 means memory never answers.
  task automatic access(input logic we, input logic bt, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] rdata,
                        input int resp_after, input logic [15:0] exp_addr,
                        input logic [1:0] exp_be, input logic [15:0] exp_wdata,
                        input int exp_cycles);
    rsp_t e;
    int   cycles;
    logic strobe;
    check("ready_before", 32'(req_ready), 32'd1);
    if (we) begin
      e.data = last_data; e.err = 1'b0;
    end else if (resp_after == 0) begin
      e.data = 16'h0000; e.err = 1'b1;
    end else if (bt) begin
      e.data = addr[0] ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]}; e.err = 1'b0;
    end else begin
      e.data = rdata; e.err = 1'b0;
    end
    last_data = e.data;
    exp_q.push_back(e);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'hFFFF; req_wdata = 16'hFFFF;
    cycles = 0;
    while (cycles < 100) begin
      mem_resp = 1'b0; mem_rdata = 16'hDEAD;
      strobe = we ? mem_write : mem_read;
      if (!strobe) break;
      cycles++;
      check("mem_address", 32'(mem_address), 32'(exp_addr));
      check("other_strobe", 32'(we ? mem_read : mem_write), 32'd0);
      check("ready_busy", 32'(req_ready), 32'd0);
      if (cycles == 1) begin
        check("byte_enable", 32'(mem_byte_enable), 32'(exp_be));
        if (we) check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      end
      if (cycles == resp_after) begin
        mem_resp = 1'b1; mem_rdata = rdata;
      end
      @(negedge clk);
    end
    check("strobe_cycles", 32'(cycles), 32'(exp_cycles));
    check("rsp_latency", 32'(rsp_valid), 32'd1);
    @(negedge clk);
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_rv, exp_rdy, exp_rd;
    last_data = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outputs", {rsp_valid, rsp_err, mem_read, mem_write, mem_byte_enable},
          32'd0);
    check("rst_addr_data", {mem_address, mem_wdata}, 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Word read, unaligned address cleared, answered after 3 strobe cycles.
    access(1'b0, 1'b0, 16'h1235, 16'h0, 16'hBEEF, 3, 16'h1234, 2'b11, 16'h0, 3);
    // Byte write replicates data, one-hot enable; rsp_data holds BEEF.
    access(1'b1, 1'b1, 16'h0041, 16'h00A5, 16'h0, 2, 16'h0040, 2'b10, 16'hA5A5, 2);
    // Byte reads from both lanes.
    access(1'b0, 1'b1, 16'h0040, 16'h0, 16'h7F80, 1, 16'h0040, 2'b11, 16'h0, 1);
    access(1'b0, 1'b1, 16'h0041, 16'h0, 16'h7F80, 2, 16'h0040, 2'b11, 16'h0, 2);
    // Word write.
    access(1'b1, 1'b0, 16'h2002, 16'h1234, 16'h0, 1, 16'h2002, 2'b11, 16'h1234, 1);
    // Timeout: no mem_resp, strobe for TIMEOUT cycles, error response.
    access(1'b0, 1'b0, 16'h0100, 16'h0, 16'h0, 0, 16'h0100, 2'b11, 16'h0, 4);
    // Response on the last allowed cycle wins over timeout.
    access(1'b0, 1'b0, 16'h0200, 16'h0, 16'h4321, 4, 16'h0200, 2'b11, 16'h0, 4);

    // Stray mem_resp in IDLE is ignored.
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    check("idle_resp_ready", 32'(req_ready), 32'd1);
    check("idle_resp_strobes", {mem_read, mem_write, rsp_valid}, 32'd0);

    // Back-to-back reads with req_valid held and mem_resp on first strobe cycle.
    mem_rdata = 16'h1111;
    exp_q.push_back('{data: 16'h1111, err: 1'b0});
    exp_q.push_back('{data: 16'h1111, err: 1'b0});
    last_data = 16'h1111;
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 16'h0300;
    exp_rv  = 6'b010010;
    exp_rdy = 6'b100100;
    exp_rd  = 6'b001001;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 3) req_valid = 1'b0;
      check("b2b_rsp_valid", 32'(rsp_valid), 32'(exp_rv[i]));
      check("b2b_req_ready", 32'(req_ready), 32'(exp_rdy[i]));
      check("b2b_mem_read", 32'(mem_read), 32'(exp_rd[i]));
      mem_resp = mem_read;
    end
    mem_resp = 1'b0; mem_rdata = 16'hDEAD;

    // Reset during a write strobe drops it at once with no response.
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h3000;
    req_wdata = 16'h5555;
    @(negedge clk);
    req_valid = 1'b0;
    check("pre_rst_write", 32'(mem_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_drops_write", 32'(mem_write), 32'd0);
    check("rst_ready_async", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_ready", 32'(req_ready), 32'd1);
      check("post_rst_quiet", {rsp_valid, mem_write, mem_read}, 32'd0);
    end

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_mem_access_unit

`default_nettype wire
